// File: rtl/amba_axi4_write_txn_checker.sv
// Passive AXI4 write-channel protocol checker: payload stability, outstanding/burst accounting.
// Optional per-channel VALID-without-READY timeouts when AMBA_AXI4_WTC_TIMEOUT_EN is defined.
module amba_axi4_write_txn_checker #(
  parameter int ADDRESS_WIDTH   = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAXWAIT         = 16,
  parameter int MAX_OUTSTANDING = 4,
  localparam int CW             = $clog2(MAX_OUTSTANDING + 1),
  localparam int SW             = DATA_WIDTH / 8
) (
  input  logic                     ACLK,
  input  logic                     ARESET,
  input  logic                     AWVALID,
  input  logic                     AWREADY,
  input  logic [ADDRESS_WIDTH-1:0] AWADDR,
  input  logic [2:0]               AWPROT,
  input  logic                     WVALID,
  input  logic                     WREADY,
  input  logic                     WLAST,
  input  logic [DATA_WIDTH-1:0]    WDATA,
  input  logic [SW-1:0]            WSTRB,
  input  logic                     BVALID,
  input  logic                     BREADY,
  input  logic [1:0]               BRESP,
  output logic [6:0]               err_vec,
  output logic [2:0]               first_err,
  output logic [CW-1:0]            outstanding
);

  localparam logic [CW-1:0] MAXO = CW'(MAX_OUTSTANDING);

  logic                     aw_hs, w_last_hs, b_hs;
  logic                     aw_stall, w_stall, b_stall;
  logic                     aw_stall_q, w_stall_q, b_stall_q;
  logic [ADDRESS_WIDTH-1:0] awaddr_q;
  logic [2:0]               awprot_q;
  logic [DATA_WIDTH-1:0]    wdata_q;
  logic [SW-1:0]            wstrb_q;
  logic                     wlast_q;
  logic [1:0]               bresp_q;
  logic [CW-1:0]            wb, wb_d, out_d;
  logic                     armed;
  logic [6:0]               raw_err, new_err;
  logic [2:0]               new_idx;

  assign aw_hs     = AWVALID & AWREADY;
  assign w_last_hs = WVALID & WREADY & WLAST;
  assign b_hs      = BVALID & BREADY;
  assign aw_stall  = AWVALID & ~AWREADY;
  assign w_stall   = WVALID & ~WREADY;
  assign b_stall   = BVALID & ~BREADY;

`ifdef AMBA_AXI4_WTC_TIMEOUT_EN
  localparam int WW = $clog2(MAXWAIT + 1);
  localparam logic [WW-1:0] WMAX = WW'(MAXWAIT);
  localparam logic [WW-1:0] WLIM = WW'(MAXWAIT - 1);

  logic [WW-1:0] aw_wait, w_wait, b_wait;

  // Wait counters saturate at MAXWAIT; the error is raised on the edge that reaches it.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      aw_wait <= '0;
      w_wait  <= '0;
      b_wait  <= '0;
    end else begin
      if (!aw_stall)          aw_wait <= '0;
      else if (aw_wait != WMAX) aw_wait <= aw_wait + WW'(1);
      if (!w_stall)           w_wait <= '0;
      else if (w_wait != WMAX)  w_wait <= w_wait + WW'(1);
      if (!b_stall)           b_wait <= '0;
      else if (b_wait != WMAX)  b_wait <= b_wait + WW'(1);
    end
  end
`endif

  always_comb begin
    raw_err    = '0;
    raw_err[0] = aw_stall_q & (~AWVALID | (AWADDR != awaddr_q) | (AWPROT != awprot_q));
    raw_err[1] = w_stall_q & (~WVALID | (WDATA != wdata_q) | (WSTRB != wstrb_q) |
                              (WLAST != wlast_q));
    raw_err[2] = b_stall_q & (~BVALID | (BRESP != bresp_q));
    raw_err[3] = b_hs & ((outstanding == '0) | (wb == '0));
    raw_err[4] = ~b_hs & ((aw_hs & (outstanding == MAXO)) | (w_last_hs & (wb == MAXO)));
`ifdef AMBA_AXI4_WTC_TIMEOUT_EN
    raw_err[5] = (aw_stall & (aw_wait == WLIM)) | (w_stall & (w_wait == WLIM));
    raw_err[6] = b_stall & (b_wait == WLIM);
`endif
    // Checks stay quiet on the first edge after reset release.
    new_err = armed ? raw_err : '0;
    new_idx = 3'd7;
    for (int i = 6; i >= 0; i--) begin
      if (new_err[i]) new_idx = 3'(i);
    end
  end

  // Counters hold on simultaneous increment/decrement and clamp at both ends.
  always_comb begin
    out_d = outstanding;
    wb_d  = wb;
    if (aw_hs && !b_hs && outstanding != MAXO)      out_d = outstanding + CW'(1);
    else if (b_hs && !aw_hs && outstanding != '0)   out_d = outstanding - CW'(1);
    if (w_last_hs && !b_hs && wb != MAXO)           wb_d = wb + CW'(1);
    else if (b_hs && !w_last_hs && wb != '0)        wb_d = wb - CW'(1);
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      err_vec     <= '0;
      first_err   <= 3'd7;
      outstanding <= '0;
      wb          <= '0;
      armed       <= 1'b0;
      aw_stall_q  <= 1'b0;
      w_stall_q   <= 1'b0;
      b_stall_q   <= 1'b0;
      awaddr_q    <= '0;
      awprot_q    <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      wlast_q     <= 1'b0;
      bresp_q     <= '0;
    end else begin
      armed       <= 1'b1;
      outstanding <= out_d;
      wb          <= wb_d;
      err_vec     <= err_vec | new_err;
      if (err_vec == '0 && new_err != '0) first_err <= new_idx;
      aw_stall_q  <= aw_stall;
      w_stall_q   <= w_stall;
      b_stall_q   <= b_stall;
      awaddr_q    <= AWADDR;
      awprot_q    <= AWPROT;
      wdata_q     <= WDATA;
      wstrb_q     <= WSTRB;
      wlast_q     <= WLAST;
      bresp_q     <= BRESP;
    end
  end

endmodule

// File: tb/tb_amba_axi4_write_txn_checker.sv
// Scoreboard bench for amba_axi4_write_txn_checker: expected {err_vec, first_err, outstanding}
// is queued per driven cycle and popped after the edge; honours AMBA_AXI4_WTC_TIMEOUT_EN.
module tb_amba_axi4_write_txn_checker;

  typedef struct packed {
    logic [6:0] e;
    logic [2:0] f;
    logic [2:0] o;
  } exp_t;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic        AWVALID, AWREADY, WVALID, WREADY, WLAST, BVALID, BREADY;
  logic [31:0] AWADDR, WDATA;
  logic [2:0]  AWPROT;
  logic [3:0]  WSTRB;
  logic [1:0]  BRESP;
  logic [6:0]  err_vec;
  logic [2:0]  first_err;
  logic [2:0]  outstanding;

  exp_t  exp_q[$];
  string name_q[$];
  exp_t  got, want;
  string nm;
  int    n_checks = 0;
  int    n_fails = 0;

  amba_axi4_write_txn_checker dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWPROT(AWPROT),
    .WVALID(WVALID), .WREADY(WREADY), .WLAST(WLAST), .WDATA(WDATA), .WSTRB(WSTRB),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
    .err_vec(err_vec), .first_err(first_err), .outstanding(outstanding)
  );

  always #5 ACLK = ~ACLK;

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic drive_aw(input logic v, input logic r, input logic [31:0] a);
    AWVALID = v; AWREADY = r; AWADDR = a; AWPROT = 3'd2;
  endtask

  task automatic drive_w(input logic v, input logic r, input logic l, input logic [31:0] d);
    WVALID = v; WREADY = r; WLAST = l; WDATA = d; WSTRB = 4'hf;
  endtask

  task automatic drive_b(input logic v, input logic r, input logic [1:0] resp);
    BVALID = v; BREADY = r; BRESP = resp;
  endtask

  task automatic idle();
    drive_aw(1'b0, 1'b0, 32'h0);
    drive_w(1'b0, 1'b0, 1'b0, 32'h0);
    drive_b(1'b0, 1'b0, 2'd0);
  endtask

  task automatic push(input logic [6:0] e, input logic [2:0] f, input logic [2:0] o,
                      input string n);
    exp_q.push_back('{e: e, f: f, o: o});
    name_q.push_back(n);
  endtask

  task automatic do_reset();
    idle();
    ARESET = 1'b1;
    tick();
    ARESET = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    idle();
    ARESET = 1'b1;
    for (int i = 0; i < 2; i++) begin
      if (i == 1) ARESET = 1'b0;
      push(7'h00, 3'd7, 3'd0, i == 0 ? "reset_asserted" : "first_edge_after_reset");
      tick();
      got = {err_vec, first_err, outstanding};
      want = exp_q.pop_front(); nm = name_q.pop_front(); n_checks++;
      if (got !== want) begin
        n_fails++;
        $display("[TB] FAIL %s: got e=%h f=%0d o=%0d want e=%h f=%0d o=%0d",
                 nm, got.e, got.f, got.o, want.e, want.f, want.o);
      end
    end
  endtask

  task automatic test_aw_stability();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      idle();
      case (i)
        0: begin drive_aw(1'b1, 1'b0, 32'h100); push(7'h00, 3'd7, 3'd0, "aw_stall"); end
        1: begin drive_aw(1'b1, 1'b0, 32'h104); push(7'h01, 3'd0, 3'd0, "aw_addr_change"); end
        2: begin drive_w(1'b1, 1'b0, 1'b0, 32'h1); push(7'h01, 3'd0, 3'd0, "aw_drop_w_stall"); end
        default: begin drive_w(1'b1, 1'b0, 1'b0, 32'h2); push(7'h03, 3'd0, 3'd0, "w_data_change"); end
      endcase
      tick();
      got = {err_vec, first_err, outstanding};
      want = exp_q.pop_front(); nm = name_q.pop_front(); n_checks++;
      if (got !== want) begin
        n_fails++;
        $display("[TB] FAIL %s: got e=%h f=%0d o=%0d want e=%h f=%0d o=%0d",
                 nm, got.e, got.f, got.o, want.e, want.f, want.o);
      end
    end
  endtask

  task automatic test_b_stability();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      idle();
      case (i)
        0: begin drive_b(1'b1, 1'b0, 2'd0); push(7'h00, 3'd7, 3'd0, "b_stall"); end
        1: begin drive_b(1'b1, 1'b0, 2'd1); push(7'h04, 3'd2, 3'd0, "b_resp_change"); end
        default: push(7'h04, 3'd2, 3'd0, "b_sticky");
      endcase
      tick();
      got = {err_vec, first_err, outstanding};
      want = exp_q.pop_front(); nm = name_q.pop_front(); n_checks++;
      if (got !== want) begin
        n_fails++;
        $display("[TB] FAIL %s: got e=%h f=%0d o=%0d want e=%h f=%0d o=%0d",
                 nm, got.e, got.f, got.o, want.e, want.f, want.o);
      end
    end
  endtask

  task automatic test_stall_then_accept();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      idle();
      case (i)
        0: begin drive_aw(1'b1, 1'b0, 32'h200); push(7'h00, 3'd7, 3'd0, "aw_stall_hold"); end
        1: begin drive_aw(1'b1, 1'b1, 32'h200); push(7'h00, 3'd7, 3'd1, "aw_accept_stable"); end
        default: push(7'h00, 3'd7, 3'd1, "aw_after_accept");
      endcase
      tick();
      got = {err_vec, first_err, outstanding};
      want = exp_q.pop_front(); nm = name_q.pop_front(); n_checks++;
      if (got !== want) begin
        n_fails++;
        $display("[TB] FAIL %s: got e=%h f=%0d o=%0d want e=%h f=%0d o=%0d",
                 nm, got.e, got.f, got.o, want.e, want.f, want.o);
      end
    end
  endtask

  task automatic test_outstanding();
    logic [2:0] seq [6] = '{3'd1, 3'd2, 3'd2, 3'd2, 3'd1, 3'd0};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      idle();
      if (i < 2)      drive_aw(1'b1, 1'b1, 32'h1000 + 32'(i * 16));
      else if (i < 4) drive_w(1'b1, 1'b1, 1'b1, 32'hA0 + 32'(i));
      else            drive_b(1'b1, 1'b1, 2'(i));
      push(7'h00, 3'd7, seq[i], "outstanding_seq");
      tick();
      got = {err_vec, first_err, outstanding};
      want = exp_q.pop_front(); nm = name_q.pop_front(); n_checks++;
      if (got !== want) begin
        n_fails++;
        $display("[TB] FAIL %s[%0d]: got e=%h f=%0d o=%0d want e=%h f=%0d o=%0d",
                 nm, i, got.e, got.f, got.o, want.e, want.f, want.o);
      end
    end
  endtask

  task automatic test_b_underflow();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      idle();
      if (i == 0) drive_b(1'b1, 1'b1, 2'd3);
      push(7'h08, 3'd3, 3'd0, i == 0 ? "b_underflow" : "b_underflow_sticky");
      tick();
      got = {err_vec, first_err, outstanding};
      want = exp_q.pop_front(); nm = name_q.pop_front(); n_checks++;
      if (got !== want) begin
        n_fails++;
        $display("[TB] FAIL %s: got e=%h f=%0d o=%0d want e=%h f=%0d o=%0d",
                 nm, got.e, got.f, got.o, want.e, want.f, want.o);
      end
    end
  endtask

  task automatic test_max_outstanding();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      idle();
      drive_aw(1'b1, 1'b1, 32'h3000 + 32'(i * 4));
      if (i < 4) push(7'h00, 3'd7, 3'(i + 1), "aw_fill");
      else       push(7'h10, 3'd4, 3'd4, "aw_overflow");
      tick();
      got = {err_vec, first_err, outstanding};
      want = exp_q.pop_front(); nm = name_q.pop_front(); n_checks++;
      if (got !== want) begin
        n_fails++;
        $display("[TB] FAIL %s[%0d]: got e=%h f=%0d o=%0d want e=%h f=%0d o=%0d",
                 nm, i, got.e, got.f, got.o, want.e, want.f, want.o);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      idle();
      if (i < 4) begin
        drive_aw(1'b1, 1'b1, 32'h4000 + 32'(i));
        push(7'h00, 3'd7, 3'(i + 1), "b2b_aw");
      end else if (i < 8) begin
        drive_w(1'b1, 1'b1, 1'b1, 32'hBEEF0000 + 32'(i));
        push(7'h00, 3'd7, 3'd4, "b2b_wlast");
      end else if (i == 8) begin
        drive_aw(1'b1, 1'b1, 32'h4100);
        drive_b(1'b1, 1'b1, 2'd2);
        push(7'h00, 3'd7, 3'd4, "aw_and_b_at_max");
      end else begin
        drive_b(1'b1, 1'b1, 2'd1);
        push(7'h00, 3'd7, 3'd3, "b_after_max");
      end
      tick();
      got = {err_vec, first_err, outstanding};
      want = exp_q.pop_front(); nm = name_q.pop_front(); n_checks++;
      if (got !== want) begin
        n_fails++;
        $display("[TB] FAIL %s[%0d]: got e=%h f=%0d o=%0d want e=%h f=%0d o=%0d",
                 nm, i, got.e, got.f, got.o, want.e, want.f, want.o);
      end
    end
  endtask

  task automatic test_timeout();
    do_reset();
    for (int i = 0; i < 17; i++) begin
      idle();
      drive_w(1'b1, (i == 16), 1'b0, 32'h5A5A5A5A);
`ifdef AMBA_AXI4_WTC_TIMEOUT_EN
      if (i < 15) push(7'h00, 3'd7, 3'd0, "w_wait_below_max");
      else        push(7'h20, 3'd5, 3'd0, "w_wait_reached_max");
`else
      push(7'h00, 3'd7, 3'd0, "w_wait_no_timeout");
`endif
      tick();
      got = {err_vec, first_err, outstanding};
      want = exp_q.pop_front(); nm = name_q.pop_front(); n_checks++;
      if (got !== want) begin
        n_fails++;
        $display("[TB] FAIL %s[%0d]: got e=%h f=%0d o=%0d want e=%h f=%0d o=%0d",
                 nm, i, got.e, got.f, got.o, want.e, want.f, want.o);
      end
    end
  endtask

  task automatic test_reset_clears();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      idle();
      ARESET = 1'b0;
      case (i)
        0: begin drive_aw(1'b1, 1'b1, 32'h6000); push(7'h00, 3'd7, 3'd1, "rc_aw"); end
        1: begin drive_b(1'b1, 1'b1, 2'd0); push(7'h08, 3'd3, 3'd0, "rc_b_no_burst"); end
        2: begin drive_aw(1'b1, 1'b1, 32'h6010); push(7'h08, 3'd3, 3'd1, "rc_aw_again"); end
        3: begin ARESET = 1'b1; push(7'h00, 3'd7, 3'd0, "rc_reset"); end
        4: push(7'h00, 3'd7, 3'd0, "rc_after_reset");
        default: begin drive_aw(1'b1, 1'b1, 32'h6020); push(7'h00, 3'd7, 3'd1, "rc_fresh_count"); end
      endcase
      tick();
      got = {err_vec, first_err, outstanding};
      want = exp_q.pop_front(); nm = name_q.pop_front(); n_checks++;
      if (got !== want) begin
        n_fails++;
        $display("[TB] FAIL %s: got e=%h f=%0d o=%0d want e=%h f=%0d o=%0d",
                 nm, got.e, got.f, got.o, want.e, want.f, want.o);
      end
    end
    ARESET = 1'b0;
  endtask

  initial begin
    idle();
    test_reset();
    test_aw_stability();
    test_b_stability();
    test_stall_then_accept();
    test_outstanding();
    test_b_underflow();
    test_max_outstanding();
    test_back_to_back();
    test_timeout();
    test_reset_clears();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/amba_axi4_write_txn_checker.md
AMBA_AXI4_WRITE_TXN_CHECKER -- requirements
Module: amba_axi4_write_txn_checker

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 32: AWADDR width.
REQ-002 Parameter DATA_WIDTH, default 32: WDATA width; WSTRB width is DATA_WIDTH/8.
REQ-003 Parameter MAXWAIT, default 16: maximum VALID-without-READY cycles per channel.
REQ-004 Parameter MAX_OUTSTANDING, default 4: maximum accepted-but-unresponded writes; counters are CW=$clog2(MAX_OUTSTANDING+1) bits.
REQ-005 ACLK  in  1  sole clock; all logic on its rising edge.
REQ-006 ARESET  in  1  reset, synchronous and active-high.
REQ-007 AWVALID, AWREADY  in  1 each  AW handshake.
REQ-008 AWADDR  in  ADDRESS_WIDTH;  AWPROT  in  3  AW payload.
REQ-009 WVALID, WREADY, WLAST  in  1 each  W handshake and burst end.
REQ-010 WDATA  in  DATA_WIDTH;  WSTRB  in  DATA_WIDTH/8  W payload.
REQ-011 BVALID, BREADY  in  1 each;  BRESP  in  2  B channel.
REQ-012 err_vec  out  7  sticky error flags, bit map per REQ-020.
REQ-013 first_err  out  3  index of the first error bit set; 7 = none.
REQ-014 outstanding  out  CW  current AW-handshakes minus B-handshakes.

Function
REQ-015 Handshake on a channel = VALID&&READY in the same cycle; the checker drives no AXI signal.
REQ-016 Stability: if cycle N has AWVALID=1, AWREADY=0, then cycle N+1 SHALL have AWVALID=1 and AWADDR/AWPROT equal to cycle N, else set err_vec[0]; same rule for W (WDATA, WSTRB, WLAST) sets err_vec[1], for B (BRESP) sets err_vec[2].
REQ-017 Outstanding counter: +1 on AW handshake, -1 on B handshake, unchanged on both or neither in the same cycle.
REQ-018 Burst counter wb: +1 on W handshake with WLAST=1, -1 on B handshake, unchanged on both in the same cycle.
REQ-019 B handshake while outstanding==0 or wb==0 (pre-update values) SHALL set err_vec[3] and leave the zero counter at 0, with no wrap-around.
REQ-020 AW handshake while outstanding==MAX_OUTSTANDING without a simultaneous B handshake SHALL set err_vec[4]; the counter saturates. A WLAST handshake with wb==MAX_OUTSTANDING and no B handshake sets err_vec[4] and wb saturates. Bits [5],[6] are defined in REQ-025.
REQ-021 Error flags are registered: a violation sampled at edge N is visible after edge N, and flags stay set until reset.
REQ-022 first_err latches the lowest-index bit newly set in the first cycle any flag rises; later errors do not change it.
REQ-023 BRESP values are not checked; all four encodings are legal.

Reset
REQ-024 With ARESET=1 at an edge: err_vec=0, first_err=7, outstanding=0, wb=0, wait counters=0, stability history cleared. No check fires on the first edge after ARESET deasserts. Reset in mid-burst discards all tracked transactions.

Configuration
REQ-025 Macro AMBA_AXI4_WTC_TIMEOUT_EN is defined: per-channel wait counters count consecutive cycles with VALID=1, READY=0 and clear on handshake or when VALID=0. Reaching MAXWAIT on AW or W sets err_vec[5]; reaching it on B sets err_vec[6]. Counters saturate.
REQ-026 Macro not defined: no wait counters exist, and err_vec[6:5] is tied to 0.

Verification
REQ-027 AWVALID=1, AWREADY=0, AWADDR=0x100, then the next cycle AWADDR=0x104 -> err_vec=0x01, first_err=0.
REQ-028 Two AW handshakes, two WLAST handshakes, then two B handshakes -> outstanding goes 1,2,2,2,1,0; err_vec stays 0.
REQ-029 BVALID=BREADY=1 straight after reset, with no AW -> err_vec[3]=1, outstanding stays 0.
REQ-030 MAX_OUTSTANDING=4: five AW handshakes with no B -> err_vec[4]=1, outstanding=4; an AW and a B in the same cycle at 4 -> no new error, count stays 4.
REQ-031 With TIMEOUT_EN defined and MAXWAIT=16: WVALID=1, WREADY=0 for 16 cycles -> err_vec[5]=1. Without the macro, the same stimulus leaves err_vec=0.
REQ-032 Errors are set, then ARESET=1 for 1 cycle -> err_vec=0, first_err=7, outstanding=0 on the following cycle.
